sdram_host_queue: RTL and testbench

- Request queue and sequencer that sits directly upstream of the single-access SDRAM controller.
- Accepts read/write commands from a host over a valid/ready interface and buffers them in a small in-order FIFO.
- Issues them one at a time on the controller's wr_enable/rd_enable/busy interface, holding each request until the controller provably accepts it (a refresh can silently defer it).
- Returns read data on a valid/ready response port.

---
 rtl/sdram_host_queue.sv | 191 +++++++++++++++++++
 tb/tb_sdram_host_queue.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_queue.sv
// Host-side command queue and sequencer in front of the single-access SDRAM controller.
// Buffers read/write commands in order, holds each one until the controller takes it, and returns read data.
module sdram_host_queue #(
  parameter int unsigned HADDR_WIDTH    = 24,
  parameter int unsigned FIFO_AW        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [HADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic                   err,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [15:0]            rd_data,
  input  logic                   rd_ready,
  input  logic                   busy
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned TW    = 10;

  typedef struct packed {
    logic                   we;
    logic [HADDR_WIDTH-1:0] addr;
    logic [15:0]            wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_t;

  cmd_t                   mem_q [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_q;
  logic [FIFO_AW-1:0]     rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   cmd_ready_q;
  cmd_t                   head;
  cmd_t                   push_cmd;
  logic                   push;
  logic                   pop;

  state_t                 state_q;
  logic [HADDR_WIDTH-1:0] wr_addr_q;
  logic [HADDR_WIDTH-1:0] rd_addr_q;
  logic [15:0]            wr_data_q;
  logic                   wr_en_q;
  logic                   rd_en_q;
  logic                   is_wr_q;
  logic                   have_q;
  logic [15:0]            hold_q;
  logic [TW-1:0]          timer_q;
  logic                   tmo_q;
  logic                   rsp_valid_q;
  logic [15:0]            rsp_data_q;
  logic                   err_q;

  assign head     = mem_q[rd_ptr_q];
  assign push_cmd = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign push     = cmd_valid && cmd_ready_q;
  // A read must wait for the response slot to be free; writes never do.
  assign pop      = (state_q == ST_IDLE) && (count_q != '0) && (head.we || !rsp_valid_q);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CW'(DEPTH));
    end
  end

  // Sequencer: issue one access, hold it until busy is seen, then collect completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      have_q      <= 1'b0;
      hold_q      <= '0;
      timer_q     <= '0;
      tmo_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            wr_addr_q <= head.addr;
            rd_addr_q <= head.addr;
            wr_data_q <= head.wdata;
            wr_en_q   <= head.we;
            rd_en_q   <= !head.we;
            is_wr_q   <= head.we;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A refresh may ignore the enable for a while, so keep it up until busy.
          if (busy) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            have_q  <= 1'b0;
            tmo_q   <= 1'b0;
            timer_q <= '0;
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!is_wr_q && rd_ready && !tmo_q) begin
            hold_q <= rd_data;
            have_q <= 1'b1;
          end else if (!is_wr_q && !have_q && !tmo_q) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              tmo_q <= 1'b1;
              err_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          if (!busy) begin
            state_q <= ST_IDLE;
            if (!is_wr_q && !tmo_q && (have_q || rd_ready)) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rd_ready ? rd_data : hold_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_enable = wr_en_q;
  assign rd_addr   = rd_addr_q;
  assign rd_enable = rd_en_q;

endmodule

// File: tb/tb_sdram_host_queue.sv
// Bench for sdram_host_queue: directed vector table, corner-case sequences, and randomized traffic
// against a controller model plus an in-order command/response scoreboard.
module tb_sdram_host_queue;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [15:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [15:0]   rsp_data;
  logic          err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_enable;
  logic [AW-1:0] rd_addr;
  logic          rd_enable;
  logic [15:0]   rd_data = '0;
  logic          rd_ready = 1'b0;
  logic          busy = 1'b0;

  sdram_host_queue #(.HADDR_WIDTH(AW), .FIFO_AW(2), .TIMEOUT_CYCLES(1023)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err(err),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic [15:0] data; } cmd_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [15:0] data; logic gets_data; } acc_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [15:0] wdata; int defer; bit same; logic [15:0] exp_rsp; } vec_t;

  int tests = 0;
  int fails = 0;

  cmd_t        exp_issue[$];
  acc_t        acc_q[$];
  logic [15:0] exp_rsp[$];

  // Controller model knobs and private state.
  int            defer_cfg = 0;
  int            busy_len = 3;
  bit            hold_busy = 0, stuck = 0, no_rdready = 0, rdy_same = 0, rand_ctrl = 0;
  int            wait_cnt = 0, c_cnt = 0;
  bit            c_dat = 0, c_same = 0;
  logic [AW-1:0] c_addr = '0;

  vec_t vt[7];

  function automatic logic [15:0] rfn(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5B5;
  endfunction

  function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function void flag_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: condition not met at %0t", nm, $time);
  endfunction

  // Single-access controller: takes an enable (after optional refresh deferral), stays busy, returns read data.
  task automatic ctrl_model();
    forever begin
      @(posedge clk);
      rd_ready <= 1'b0;
      if (rst) begin
        busy     <= 1'b0;
        wait_cnt = 0;
      end else if (!busy) begin
        if ((wr_enable || rd_enable) && !stuck) begin
          if (wait_cnt < defer_cfg) begin
            wait_cnt++;
          end else begin
            wait_cnt = 0;
            busy   <= 1'b1;
            c_addr = rd_enable ? rd_addr : wr_addr;
            c_dat  = rd_enable && !no_rdready;
            c_cnt  = rand_ctrl ? int'($urandom_range(1, 4)) : busy_len;
            c_same = rand_ctrl ? 1'($urandom_range(0, 1)) : rdy_same;
            acc_q.push_back('{we: wr_enable, addr: c_addr, data: wr_data, gets_data: c_dat});
          end
        end
      end else if (!hold_busy) begin
        if (c_cnt == 1 && c_dat && !c_same) begin
          rd_ready <= 1'b1;
          rd_data  <= rfn(c_addr);
        end
        if (c_cnt == 0) begin
          busy <= 1'b0;
          if (c_dat && c_same) begin
            rd_ready <= 1'b1;
            rd_data  <= rfn(c_addr);
          end
        end else begin
          c_cnt--;
        end
      end
    end
  endtask

  // Scoreboard: pushes must issue in order, reads must answer in order with the controller's data.
  task automatic monitor();
    acc_t a;
    cmd_t e;
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_enable && rd_enable) flag_fail("enables_exclusive");
        if (cmd_valid && cmd_ready) exp_issue.push_back('{we: cmd_we, addr: cmd_addr, data: cmd_wdata});
        while (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          if (exp_issue.size() == 0) begin
            flag_fail("issue_unexpected");
          end else begin
            e = exp_issue.pop_front();
            chk("issue_we", 32'(a.we), 32'(e.we));
            chk("issue_addr", 32'(a.addr), 32'(e.addr));
            if (e.we) chk("issue_wdata", 32'(a.data), 32'(e.data));
            if (a.gets_data) exp_rsp.push_back(rfn(e.addr));
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            flag_fail("rsp_unexpected");
          end else begin
            r = exp_rsp.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(r));
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_issue.delete();
    acc_q.delete();
    exp_rsp.delete();
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || busy || wr_enable || rd_enable || rsp_valid) && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) flag_fail("idle_timeout");
    tick();
    tick();
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [15:0] d);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) flag_fail("push_timeout");
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int g;
    int n;
    bit seen;
    fork
      ctrl_model();
      monitor();
      watchdog();
    join_none

    vt[0] = '{we: 1'b1, addr: 24'h012345, wdata: 16'hBEEF, defer: 0,  same: 1'b0, exp_rsp: 16'h0000};
    vt[1] = '{we: 1'b0, addr: 24'h000010, wdata: 16'h0000, defer: 0,  same: 1'b0, exp_rsp: 16'hA5A5};
    vt[2] = '{we: 1'b0, addr: 24'h0ABCDE, wdata: 16'h0000, defer: 12, same: 1'b0, exp_rsp: 16'h196B};
    vt[3] = '{we: 1'b0, addr: 24'hFFFFFF, wdata: 16'h0000, defer: 0,  same: 1'b1, exp_rsp: 16'h5A4A};
    vt[4] = '{we: 1'b1, addr: 24'h000000, wdata: 16'h0000, defer: 3,  same: 1'b0, exp_rsp: 16'h0000};
    vt[5] = '{we: 1'b1, addr: 24'hFFFFFF, wdata: 16'hFFFF, defer: 0,  same: 1'b0, exp_rsp: 16'h0000};
    vt[6] = '{we: 1'b0, addr: 24'h800001, wdata: 16'h0000, defer: 2,  same: 1'b1, exp_rsp: 16'hA5B4};

    do_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_enables", 32'({wr_enable, rd_enable}), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);

    // Directed single transactions from the vector table.
    for (int i = 0; i < 7; i++) begin
      rsp_ready = 1'b1;
      wait_idle();
      defer_cfg = vt[i].defer;
      rdy_same  = vt[i].same;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = vt[i].we;
      cmd_addr  = vt[i].addr;
      cmd_wdata = vt[i].wdata;
      chk("v_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("v_en_n1", 32'({wr_enable, rd_enable}), 32'd0);
      tick();
      chk("v_en_n2", 32'({wr_enable, rd_enable}), vt[i].we ? 32'd2 : 32'd1);
      chk("v_addr", vt[i].we ? 32'(wr_addr) : 32'(rd_addr), 32'(vt[i].addr));
      if (vt[i].we) chk("v_wdata", 32'(wr_data), 32'(vt[i].wdata));
      for (int d = 0; d < vt[i].defer; d++) begin
        tick();
        chk("v_hold_en", 32'({wr_enable, rd_enable}), vt[i].we ? 32'd2 : 32'd1);
        chk("v_hold_addr", vt[i].we ? 32'(wr_addr) : 32'(rd_addr), 32'(vt[i].addr));
      end
      g = 0;
      while (!busy && g < 50) begin tick(); g++; end
      if (g >= 50) flag_fail("v_busy_timeout");
      tick();
      chk("v_en_drop", 32'({wr_enable, rd_enable}), 32'd0);
      if (!vt[i].we) begin
        g = 0;
        while (!rsp_valid && g < 50) begin tick(); g++; end
        if (g >= 50) flag_fail("v_rsp_timeout");
        chk("v_rsp_data", 32'(rsp_data), 32'(vt[i].exp_rsp));
        tick();
        tick();
        chk("v_rsp_hold", 32'({rsp_valid, rsp_data}), 32'({1'b1, vt[i].exp_rsp}));
        rsp_ready = 1'b1;
        tick();
        chk("v_rsp_clear", 32'(rsp_valid), 32'd0);
      end else begin
        chk("v_wr_cmd_ready", 32'(cmd_ready), 32'd1);
      end
    end
    defer_cfg = 0;
    rdy_same  = 1'b0;
    rsp_ready = 1'b1;

    // Response backpressure blocks the next read.
    wait_idle();
    rsp_ready = 1'b0;
    push(1'b0, 24'h000100, 16'h0);
    push(1'b0, 24'h000200, 16'h0);
    g = 0;
    while (!rsp_valid && g < 100) begin tick(); g++; end
    if (g >= 100) flag_fail("bp_rsp_timeout");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_rd_enable_low", 32'({rsp_valid, rd_enable}), 32'd2);
    end
    rsp_ready = 1'b1;
    g = 0;
    while (!rd_enable && g < 20) begin tick(); g++; end
    if (g >= 20) flag_fail("bp_second_issue_timeout");
    chk("bp_second_addr", 32'(rd_addr), 32'h000200);
    wait_idle();

    // Full FIFO while the controller is stuck busy.
    push(1'b1, 24'h000AAA, 16'h1111);
    g = 0;
    while (!busy && g < 20) begin tick(); g++; end
    hold_busy = 1'b1;
    push(1'b1, 24'h000BBB, 16'h2222);
    push(1'b0, 24'h000CCC, 16'h0);
    push(1'b1, 24'h000DDD, 16'h4444);
    push(1'b0, 24'h000EEE, 16'h0);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 24'h000FFF;
    cmd_wdata = 16'h6666;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("full_blocked", 32'(cmd_ready), 32'd0);
    end
    hold_busy = 1'b0;
    push(1'b1, 24'h000FFF, 16'h6666);
    wait_idle();
    chk("full_drained", 32'(exp_issue.size()), 32'd0);

    // Randomized traffic with a randomized controller.
    rand_ctrl = 1'b1;
    for (int k = 0; k < 800; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_we    = 1'($urandom_range(0, 1));
      cmd_addr  = 24'($urandom);
      cmd_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      defer_cfg = int'($urandom_range(0, 2));
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    defer_cfg = 0;
    wait_idle();
    rand_ctrl = 1'b0;
    chk("rand_issue_drained", 32'(exp_issue.size()), 32'd0);
    chk("rand_rsp_drained", 32'(exp_rsp.size()), 32'd0);
    chk("rand_err_clear", 32'(err), 32'd0);

    // Read timeout: no rd_ready while busy stays high.
    no_rdready = 1'b1;
    busy_len   = 1100;
    push(1'b0, 24'h00F00F, 16'h0);
    g = 0;
    while (!busy && g < 20) begin tick(); g++; end
    n = 0;
    while (!err && n < 1200) begin tick(); n++; end
    chk("tmo_cycles", 32'(n), 32'd1024);
    chk("tmo_err", 32'(err), 32'd1);
    seen = 0;
    g = 0;
    while ((busy || g < 3) && g < 200) begin
      tick();
      g++;
      if (rsp_valid) seen = 1;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    chk("tmo_no_rsp", 32'(seen), 32'd0);
    no_rdready = 1'b0;
    busy_len   = 3;
    push(1'b1, 24'h000123, 16'h7777);
    wait_idle();
    chk("tmo_err_sticky", 32'(err), 32'd1);

    // Reset while a read is being held in issue.
    stuck = 1'b1;
    push(1'b0, 24'h000321, 16'h0);
    g = 0;
    while (!rd_enable && g < 20) begin tick(); g++; end
    tick();
    tick();
    chk("mid_rd_enable", 32'(rd_enable), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_enables", 32'({wr_enable, rd_enable}), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst   = 1'b0;
    stuck = 1'b0;
    exp_issue.delete();
    acc_q.delete();
    exp_rsp.delete();
    tick();

    // Normal operation after reset.
    push(1'b1, 24'h00CAFE, 16'h1234);
    push(1'b0, 24'h00CAFE, 16'h0);
    wait_idle();
    chk("post_rst_drained", 32'(exp_issue.size() + exp_rsp.size()), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
